// File: rtl/sprite_pixel_fetch_if.sv
// Sprite-sheet ROM bus: registered address out, palette index back
// one cycle later from a synchronous ROM.
interface sprite_pixel_fetch_if #(
    parameter int AW = 14
);
    logic [AW-1:0] rom_addr;
    logic [4:0]    rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite compositor: hit-tests frame-latched sprite slots,
// fetches the winning texel, emits a palette index (3-cycle latency).
// Optional macro SPRITE_HFLIP_EN adds per-slot horizontal flip.
module sprite_pixel_fetch #(
    parameter int         NUM_SPR = 4,
    parameter int         SPR_W   = 16,
    parameter int         SPR_H   = 16,
    parameter int         ID_W    = 6,
    parameter int         AW      = ID_W + $clog2(SPR_W) + $clog2(SPR_H),
    parameter logic [4:0] BG_IDX  = 5'd1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [NUM_SPR-1:0]       spr_en,
    input  logic [NUM_SPR*10-1:0]    spr_x,
    input  logic [NUM_SPR*10-1:0]    spr_y,
    input  logic [NUM_SPR*ID_W-1:0]  spr_id,
`ifdef SPRITE_HFLIP_EN
    input  logic [NUM_SPR-1:0]       spr_flip,
`endif
    sprite_pixel_fetch_if.master     rom,
    output logic [4:0]               palette,
    output logic                     palette_vld
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    // Frame-latched sprite registers
    logic [NUM_SPR-1:0] en_q;
    logic [9:0]         x_q  [NUM_SPR];
    logic [9:0]         y_q  [NUM_SPR];
    logic [ID_W-1:0]    id_q [NUM_SPR];
`ifdef SPRITE_HFLIP_EN
    logic [NUM_SPR-1:0] flip_q;
`endif

    // Pipeline state
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          hit0_q, hit0_d;
    logic          vld0_q;
    logic          hit1_q;
    logic          vld1_q;
    logic [4:0]    palette_q, palette_d;
    logic          vld2_q;

    // Per-slot offsets from the sprite origin
    logic [10:0]        dx [NUM_SPR];
    logic [10:0]        dy [NUM_SPR];
    logic [NUM_SPR-1:0] hit_vec;
    logic [CW-1:0]      col [NUM_SPR];

    // Shadow live sprite registers at the start of vertical blank
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            en_q <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                id_q[i] <= '0;
            end
`ifdef SPRITE_HFLIP_EN
            flip_q <= '0;
`endif
        end else if (frame_start) begin
            en_q <= spr_en;
            for (int i = 0; i < NUM_SPR; i++) begin
                x_q[i]  <= spr_x[10*i +: 10];
                y_q[i]  <= spr_y[10*i +: 10];
                id_q[i] <= spr_id[ID_W*i +: ID_W];
            end
`ifdef SPRITE_HFLIP_EN
            flip_q <= spr_flip;
`endif
        end
    end

    // Hit test: 11-bit subtraction so negative offsets never wrap into range
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            dx[i] = {1'b0, DrawX} - {1'b0, x_q[i]};
            dy[i] = {1'b0, DrawY} - {1'b0, y_q[i]};
            hit_vec[i] = en_q[i] & pix_valid
                       & ~dx[i][10] & ((dx[i][9:0] >> CW) == 10'd0)
                       & ~dy[i][10] & ((dy[i][9:0] >> RW) == 10'd0);
`ifdef SPRITE_HFLIP_EN
            col[i] = flip_q[i] ? ~dx[i][CW-1:0] : dx[i][CW-1:0];
`else
            col[i] = dx[i][CW-1:0];
`endif
        end
    end

    // Lowest-index hit wins; address holds when nothing hits
    always_comb begin
        rom_addr_d = rom_addr_q;
        hit0_d     = 1'b0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit0_d     = 1'b1;
                rom_addr_d = {id_q[i], dy[i][RW-1:0], col[i]};
            end
        end
    end

    // Chroma key: texel 0 or no hit shows background
    always_comb begin
        palette_d = BG_IDX;
        if (hit1_q && (rom.rom_data != 5'd0)) begin
            palette_d = rom.rom_data;
        end
    end

    // Three-stage pixel pipeline, advances every cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            hit0_q     <= 1'b0;
            vld0_q     <= 1'b0;
            hit1_q     <= 1'b0;
            vld1_q     <= 1'b0;
            palette_q  <= BG_IDX;
            vld2_q     <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit0_q     <= hit0_d;
            vld0_q     <= pix_valid;
            hit1_q     <= hit0_q;
            vld1_q     <= vld0_q;
            palette_q  <= palette_d;
            vld2_q     <= vld1_q;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign palette      = palette_q;
    assign palette_vld  = vld2_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: table of single pixels plus
// sequences for overlap, shadowing, mid-frame reset and optional flip.
module tb_sprite_pixel_fetch;

    localparam int NS = 4;
    localparam int IW = 6;
    localparam int AW = 14;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           frame_start;
    logic           pix_valid;
    logic [9:0]     DrawX, DrawY;
    logic [NS-1:0]  spr_en;
    logic [NS*10-1:0] spr_x, spr_y;
    logic [NS*IW-1:0] spr_id;
`ifdef SPRITE_HFLIP_EN
    logic [NS-1:0]  spr_flip;
`endif
    logic [4:0]     palette;
    logic           palette_vld;

    sprite_pixel_fetch_if #(.AW(AW)) rom_bus ();

    sprite_pixel_fetch #(
        .NUM_SPR(NS), .SPR_W(16), .SPR_H(16),
        .ID_W(IW), .AW(AW), .BG_IDX(5'd1)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .spr_en(spr_en),
        .spr_x(spr_x),
        .spr_y(spr_y),
        .spr_id(spr_id),
`ifdef SPRITE_HFLIP_EN
        .spr_flip(spr_flip),
`endif
        .rom(rom_bus.master),
        .palette(palette),
        .palette_vld(palette_vld)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: default texel = low 5 address bits
    logic [4:0] mem [0:(1<<AW)-1];
    always @(posedge Clk) rom_bus.rom_data <= mem[rom_bus.rom_addr];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int pv;
        int addr;
        int pal;
        int vld;
    } vec_t;

    vec_t tbl [12];

    task automatic set_slot(input int s, input int en, input int x,
                            input int y, input int id);
        spr_en[s]        = en[0];
        spr_x[10*s +: 10] = 10'(x);
        spr_y[10*s +: 10] = 10'(y);
        spr_id[IW*s +: IW] = IW'(id);
    endtask

    task automatic pulse_frame();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    // One pixel in, check address after 1 edge, output after 3
    task automatic run_vec(input string nm, input vec_t v);
        @(negedge Clk);
        DrawX = 10'(v.x);
        DrawY = 10'(v.y);
        pix_valid = v.pv[0];
        @(posedge Clk); #1;
        chk({nm, " rom_addr"}, int'(rom_bus.rom_addr), v.addr);
        @(negedge Clk);
        pix_valid = 1'b0;
        @(posedge Clk); #1;
        chk({nm, " early vld"}, int'(palette_vld), 0);
        @(posedge Clk); #1;
        chk({nm, " palette"}, int'(palette), v.pal);
        chk({nm, " vld"}, int'(palette_vld), v.vld);
    endtask

    initial begin
        vec_t v;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 5'(a);
        mem[805]  = 5'd7;
        mem[1109] = 5'd0;

        tbl[0]  = '{105,  52, 1,  805,  7, 1};
        tbl[1]  = '{ 99,  52, 1,  805,  1, 1};
        tbl[2]  = '{100,  52, 1,  800,  1, 1};
        tbl[3]  = '{115,  52, 1,  815, 15, 1};
        tbl[4]  = '{116,  52, 1,  815,  1, 1};
        tbl[5]  = '{  0,   0, 1,  815,  1, 1};
        tbl[6]  = '{1023,  5, 1,  339, 19, 1};
        tbl[7]  = '{105,  52, 0,  339,  1, 0};
        tbl[8]  = '{205, 215, 1, 1525, 21, 1};
        tbl[9]  = '{205, 216, 1, 1525,  1, 1};
        tbl[10] = '{100,  65, 1, 1008, 16, 1};
        tbl[11] = '{100,  49, 1, 1008,  1, 1};

        Reset_n = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        DrawX = '0;
        DrawY = '0;
        spr_en = '0;
        spr_x = '0;
        spr_y = '0;
        spr_id = '0;
`ifdef SPRITE_HFLIP_EN
        spr_flip = '0;
`endif
        #12;
        chk("reset palette", int'(palette), 1);
        chk("reset vld", int'(palette_vld), 0);
        chk("reset rom_addr", int'(rom_bus.rom_addr), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        set_slot(0, 1, 100, 50, 3);
        set_slot(1, 1, 200, 200, 5);
        set_slot(2, 1, 1020, 0, 1);
        set_slot(3, 0, 0, 0, 7);
        pulse_frame();

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Overlap: slot0 wins with a transparent texel
        set_slot(0, 1, 195, 195, 4);
        set_slot(1, 1, 190, 190, 5);
        pulse_frame();
        v = '{200, 200, 1, 1109, 1, 1};
        run_vec("overlap", v);

        // Live change without frame_start has no effect
        set_slot(0, 1, 300, 195, 4);
        run_vec("shadow hold", v);

        // frame_start with a pixel: that pixel still uses old shadow
        @(negedge Clk);
        frame_start = 1'b1;
        DrawX = 10'd200;
        DrawY = 10'd200;
        pix_valid = 1'b1;
        @(posedge Clk); #1;
        chk("fs concurrent rom_addr", int'(rom_bus.rom_addr), 1109);
        @(negedge Clk);
        frame_start = 1'b0;
        pix_valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("fs concurrent palette", int'(palette), 1);
        chk("fs concurrent vld", int'(palette_vld), 1);
        v = '{200, 200, 1, 1450, 10, 1};
        run_vec("shadow new", v);

        // Reset mid-stream
        @(negedge Clk);
        DrawX = 10'd200;
        DrawY = 10'd200;
        pix_valid = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("pre-reset palette", int'(palette), 10);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midreset palette", int'(palette), 1);
        chk("midreset vld", int'(palette_vld), 0);
        chk("midreset rom_addr", int'(rom_bus.rom_addr), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        pix_valid = 1'b0;
        v = '{200, 200, 1, 0, 1, 1};
        run_vec("post-reset bg", v);
        pulse_frame();
        v = '{200, 200, 1, 1450, 10, 1};
        run_vec("post-reset frame", v);

`ifdef SPRITE_HFLIP_EN
        set_slot(0, 1, 100, 50, 3);
        spr_flip[0] = 1'b1;
        pulse_frame();
        v = '{100, 52, 1, 815, 15, 1};
        run_vec("hflip", v);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
